// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and helpers for the Ethernet TX scheduler
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_IFG       = 2'd2
    } sched_state_t;

    typedef enum logic {
        TX_TYPE_ARP = 1'b0,
        TX_TYPE_IP  = 1'b1
    } tx_type_t;

    localparam int DEFAULT_IFG_CYCLES     = 12;
    localparam int DEFAULT_TIMEOUT_CYCLES = 2048;
    localparam int MAC_W                  = 48;

    // Counter width for a 0..terminal-1 counter; never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - request/grant and frame-builder handshake bundle of the TX scheduler
interface eth_tx_sched_if;
    import eth_pkg::*;

    logic             arp_req;
    logic [MAC_W-1:0] arp_req_mac;
    logic             udp_req;
    logic [MAC_W-1:0] udp_dst_mac;
    logic             tx_done;
    logic             tx_start;
    logic             tx_type;
    logic [MAC_W-1:0] tx_dst_mac;
    logic             udp_grant;
    logic             arp_drop;
    logic             tx_timeout;
    logic             busy;

    // Request sources and frame builder side.
    modport master (
        output arp_req, arp_req_mac, udp_req, udp_dst_mac, tx_done,
        input  tx_start, tx_type, tx_dst_mac, udp_grant, arp_drop, tx_timeout, busy
    );

    // Scheduler side.
    modport slave (
        input  arp_req, arp_req_mac, udp_req, udp_dst_mac, tx_done,
        output tx_start, tx_type, tx_dst_mac, udp_grant, arp_drop, tx_timeout, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way ARP/IPv4 round-robin arbiter with last-grant memory
module rr_arb2
    import eth_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic req_arp,
    input  logic req_ip,
    input  logic advance,
    output logic gnt_arp,
    output logic gnt_ip
);

    tx_type_t last_grant;

    // Contended requests go to the type that did not win last time.
    always_comb begin
        gnt_arp = 1'b0;
        gnt_ip  = 1'b0;
        if (req_arp && req_ip) begin
            if (last_grant == TX_TYPE_IP) begin
                gnt_arp = 1'b1;
            end else begin
                gnt_ip = 1'b1;
            end
        end else begin
            gnt_arp = req_arp;
            gnt_ip  = req_ip;
        end
    end

    // Remember the winner only when the grant is actually taken; reset favours ARP next.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= TX_TYPE_IP;
        end else if (advance && gnt_arp) begin
            last_grant <= TX_TYPE_ARP;
        end else if (advance && gnt_ip) begin
            last_grant <= TX_TYPE_IP;
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - schedules ARP replies and UDP/IPv4 frames onto one GMII TX builder
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = DEFAULT_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         aclk,
    input  logic         aresetn,
    eth_tx_sched_if.slave bus
);

    localparam int IFG_W = cnt_width(IFG_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sched_state_t     state;
    sched_state_t     state_d;
    logic             arp_pending;
    logic [MAC_W-1:0] arp_mac;
    logic [IFG_W-1:0] ifg_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             gnt_arp;
    logic             gnt_ip;
    logic             grant;
    logic             arp_consume;

    logic             tx_start_q;
    logic             tx_start_d;
    tx_type_t         tx_type_q;
    tx_type_t         tx_type_d;
    logic [MAC_W-1:0] tx_dst_mac_q;
    logic [MAC_W-1:0] tx_dst_mac_d;
    logic             udp_grant_q;
    logic             udp_grant_d;
    logic             tx_timeout_q;
    logic             tx_timeout_d;
    logic             arp_drop_q;

    rr_arb2 u_arb (
        .clk     (aclk),
        .resetn  (aresetn),
        .req_arp (arp_pending),
        .req_ip  (bus.udp_req),
        .advance (grant),
        .gnt_arp (gnt_arp),
        .gnt_ip  (gnt_ip)
    );

    assign arp_consume = grant & gnt_arp;

    // Next state plus the values the registered outputs take at the coming edge.
    always_comb begin
        state_d      = state;
        grant        = 1'b0;
        tx_start_d   = 1'b0;
        udp_grant_d  = 1'b0;
        tx_timeout_d = 1'b0;
        tx_type_d    = tx_type_q;
        tx_dst_mac_d = tx_dst_mac_q;
        case (state)
            ST_IDLE: begin
                if (gnt_arp || gnt_ip) begin
                    grant      = 1'b1;
                    state_d    = ST_WAIT_DONE;
                    tx_start_d = 1'b1;
                    if (gnt_arp) begin
                        tx_type_d    = TX_TYPE_ARP;
                        tx_dst_mac_d = arp_mac;
                    end else begin
                        tx_type_d    = TX_TYPE_IP;
                        tx_dst_mac_d = bus.udp_dst_mac;
                        udp_grant_d  = 1'b1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                // A done arriving on the last allowed cycle still counts as a normal finish.
                if (bus.tx_done) begin
                    state_d = ST_IFG;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d      = ST_IFG;
                    tx_timeout_d = 1'b1;
                end
            end
            ST_IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Per-state cycle counters restart at 0 on entry and stop where the state is left.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tmo_cnt <= '0;
            ifg_cnt <= '0;
        end else begin
            if (state == ST_WAIT_DONE && state_d == ST_WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (state == ST_IFG && state_d == ST_IFG) begin
                ifg_cnt <= ifg_cnt + IFG_W'(1);
            end else begin
                ifg_cnt <= '0;
            end
        end
    end

    // Registered frame-builder outputs; type and MAC hold until the next grant.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tx_start_q   <= 1'b0;
            udp_grant_q  <= 1'b0;
            tx_timeout_q <= 1'b0;
            tx_type_q    <= TX_TYPE_ARP;
            tx_dst_mac_q <= '0;
        end else begin
            tx_start_q   <= tx_start_d;
            udp_grant_q  <= udp_grant_d;
            tx_timeout_q <= tx_timeout_d;
            tx_type_q    <= tx_type_d;
            tx_dst_mac_q <= tx_dst_mac_d;
        end
    end

    // One-deep ARP slot: a request landing while the slot is being granted refills it.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arp_pending <= 1'b0;
            arp_mac     <= '0;
            arp_drop_q  <= 1'b0;
        end else begin
            arp_drop_q <= 1'b0;
            if (bus.arp_req) begin
                if (arp_pending && !arp_consume) begin
                    arp_drop_q <= 1'b1;
                end else begin
                    arp_pending <= 1'b1;
                    arp_mac     <= bus.arp_req_mac;
                end
            end else if (arp_consume) begin
                arp_pending <= 1'b0;
            end
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_type    = tx_type_q;
    assign bus.tx_dst_mac = tx_dst_mac_q;
    assign bus.udp_grant  = udp_grant_q;
    assign bus.tx_timeout = tx_timeout_q;
    assign bus.arp_drop   = arp_drop_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - randomized scoreboard bench for eth_tx_sched
module tb_eth_tx_sched;
    import eth_pkg::*;

    localparam int IFG = 12;
    localparam int TMO = 2048;

    typedef struct {
        int          cyc;
        bit          typ;
        logic [47:0] mac;
    } ev_t;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    eth_tx_sched_if bus ();

    eth_tx_sched #(
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  exp_busy = 1'b0;

    // Reference model: scheduler is free from cycle m_free onwards.
    bit          m_pending = 1'b0;
    logic [47:0] m_mac = '0;
    bit          m_last = 1'b1;
    int          m_gstart = 0;
    int          m_free = 0;
    int          done_at = -1;
    bit          random_mode = 1'b0;
    int          next_delay = 5;
    bit          no_done_next = 1'b0;
    bit          udp_want = 1'b0;
    logic [47:0] udp_mac_want = '0;

    ev_t q_start[$];
    ev_t q_drop[$];
    ev_t q_tmo[$];
    ev_t mon_e;

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int  c;
        int  d;
        bit  typ;
        bit  consume;
        ev_t e;
        c = cyc;
        consume = 1'b0;
        exp_busy = (c >= m_gstart) && (c < m_free);
        if (!aresetn) begin
            while (q_start.size() > 0 && q_start[$].cyc > c) void'(q_start.pop_back());
            while (q_drop.size() > 0 && q_drop[$].cyc > c) void'(q_drop.pop_back());
            while (q_tmo.size() > 0 && q_tmo[$].cyc > c) void'(q_tmo.pop_back());
            m_pending = 1'b0;
            m_mac = '0;
            m_last = 1'b1;
            m_gstart = 0;
            m_free = 0;
            done_at = -1;
            return;
        end
        if (c >= m_free && (m_pending || bus.udp_req)) begin
            if (m_pending && bus.udp_req) typ = ~m_last;
            else typ = !m_pending;
            e.cyc = c + 1;
            e.typ = typ;
            e.mac = typ ? bus.udp_dst_mac : m_mac;
            q_start.push_back(e);
            consume = !typ;
            m_last = typ;
            m_gstart = c + 1;
            if (no_done_next) begin
                e.cyc = c + 1 + TMO;
                q_tmo.push_back(e);
                m_free = c + 1 + TMO + IFG;
                done_at = -1;
                no_done_next = 1'b0;
            end else begin
                d = random_mode ? int'($urandom_range(0, 40)) : next_delay;
                done_at = c + 1 + d;
                m_free = done_at + 1 + IFG;
            end
        end
        if (bus.arp_req) begin
            if (m_pending && !consume) begin
                e.cyc = c + 1;
                e.typ = 1'b0;
                e.mac = '0;
                q_drop.push_back(e);
            end else begin
                m_pending = 1'b1;
                m_mac = bus.arp_req_mac;
            end
        end else if (consume) begin
            m_pending = 1'b0;
        end
    endtask

    task automatic tick(input bit arp, input logic [47:0] amac, input bit rstn, input bit inj_done);
        @(posedge aclk);
        #1;
        cyc++;
        aresetn = rstn;
        bus.arp_req = arp;
        bus.arp_req_mac = amac;
        if (!rstn) begin
            bus.udp_req = 1'b0;
            udp_want = 1'b0;
        end else if (bus.udp_req && bus.udp_grant) begin
            bus.udp_req = 1'b0;
        end else if (!bus.udp_req && udp_want) begin
            bus.udp_req = 1'b1;
            bus.udp_dst_mac = udp_mac_want;
            udp_want = 1'b0;
        end
        bus.tx_done = (cyc == done_at) ||
                      (inj_done && !((cyc >= m_gstart) && (cyc < m_free - IFG)));
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, " busy"}, bus.busy, 1'b0);
        check({tag, " tx_start"}, bus.tx_start, 1'b0);
        check({tag, " udp_grant"}, bus.udp_grant, 1'b0);
        check({tag, " arp_drop"}, bus.arp_drop, 1'b0);
        check({tag, " tx_timeout"}, bus.tx_timeout, 1'b0);
        check({tag, " tx_type"}, bus.tx_type, 1'b0);
        check({tag, " tx_dst_mac"}, bus.tx_dst_mac, 48'h0);
    endtask

    // Monitor: every presented pulse must match the head of its expectation queue.
    always @(negedge aclk) begin
        if (mon_en) begin
            check("busy", bus.busy, exp_busy);
            while (q_start.size() > 0 && q_start[0].cyc < cyc) begin
                mon_e = q_start.pop_front();
                checks++;
                errors++;
                $display("FAIL tx_start missing: got none expected pulse at cycle %0d", mon_e.cyc);
            end
            if (bus.tx_start !== 1'b0) begin
                if (q_start.size() > 0 && q_start[0].cyc == cyc) begin
                    mon_e = q_start.pop_front();
                    check("tx_type", bus.tx_type, mon_e.typ);
                    check("tx_dst_mac", bus.tx_dst_mac, mon_e.mac);
                    check("udp_grant with start", bus.udp_grant, mon_e.typ);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL tx_start unexpected: got %b expected 0 at cycle %0d", bus.tx_start, cyc);
                end
            end else if (bus.udp_grant !== 1'b0) begin
                check("udp_grant without start", bus.udp_grant, 1'b0);
            end
            while (q_drop.size() > 0 && q_drop[0].cyc < cyc) begin
                mon_e = q_drop.pop_front();
                checks++;
                errors++;
                $display("FAIL arp_drop missing: got none expected pulse at cycle %0d", mon_e.cyc);
            end
            if (bus.arp_drop !== 1'b0) begin
                checks++;
                if (q_drop.size() > 0 && q_drop[0].cyc == cyc) begin
                    void'(q_drop.pop_front());
                end else begin
                    errors++;
                    $display("FAIL arp_drop unexpected: got %b expected 0 at cycle %0d", bus.arp_drop, cyc);
                end
            end
            while (q_tmo.size() > 0 && q_tmo[0].cyc < cyc) begin
                mon_e = q_tmo.pop_front();
                checks++;
                errors++;
                $display("FAIL tx_timeout missing: got none expected pulse at cycle %0d", mon_e.cyc);
            end
            if (bus.tx_timeout !== 1'b0) begin
                checks++;
                if (q_tmo.size() > 0 && q_tmo[0].cyc == cyc) begin
                    void'(q_tmo.pop_front());
                end else begin
                    errors++;
                    $display("FAIL tx_timeout unexpected: got %b expected 0 at cycle %0d", bus.tx_timeout, cyc);
                end
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        bus.arp_req = 1'b0;
        bus.arp_req_mac = '0;
        bus.udp_req = 1'b0;
        bus.udp_dst_mac = '0;
        bus.tx_done = 1'b0;

        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        reset_state_checks("reset");
        mon_en = 1'b1;

        // Uncontended ARP at cycle 10 starts at cycle 12.
        next_delay = 5;
        while (cyc < 9) idle(1);
        tick(1'b1, 48'h020000000001, 1'b1, 1'b0);
        idle(40);

        // Contention straight after reset goes to ARP first, then UDP.
        repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
        next_delay = 3;
        tick(1'b1, 48'h0a0000000aa1, 1'b1, 1'b0);
        udp_want = 1'b1;
        udp_mac_want = 48'h0b00000000b2;
        idle(70);

        // Second ARP while one is already pending is dropped.
        next_delay = 40;
        tick(1'b1, 48'h0c00000000c3, 1'b1, 1'b0);
        idle(3);
        tick(1'b1, 48'h0d00000000d4, 1'b1, 1'b0);
        idle(2);
        tick(1'b1, 48'h0e00000000e5, 1'b1, 1'b0);
        idle(120);

        // Missing tx_done times out, then the pending ARP is served.
        no_done_next = 1'b1;
        next_delay = 4;
        tick(1'b1, 48'h0f00000000f6, 1'b1, 1'b0);
        idle(3);
        tick(1'b1, 48'h1000000000a7, 1'b1, 1'b0);
        idle(TMO + IFG + 40);

        // Reset during WAIT_DONE abandons the frame and discards requests.
        next_delay = 50;
        tick(1'b1, 48'h1100000000b8, 1'b1, 1'b0);
        idle(5);
        tick(1'b1, 48'h1200000000c9, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        reset_state_checks("mid-frame reset");
        idle(80);

        // tx_done while idle changes nothing.
        repeat (5) begin
            tick(1'b0, '0, 1'b1, 1'b1);
            idle(3);
        end
        check("idle after stray tx_done", bus.busy, 1'b0);

        // Randomized traffic with stray tx_done outside WAIT_DONE.
        random_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (!bus.udp_req && !udp_want && $urandom_range(0, 14) == 0) begin
                udp_want = 1'b1;
                udp_mac_want = rand_mac();
            end
            tick($urandom_range(0, 9) == 0, rand_mac(), 1'b1, $urandom_range(0, 7) == 0);
        end
        udp_want = 1'b0;
        idle(250);

        check("tx_start queue drained", 48'(q_start.size()), 48'h0);
        check("arp_drop queue drained", 48'(q_drop.size()), 48'h0);
        check("tx_timeout queue drained", 48'(q_tmo.size()), 48'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, inter-frame gap in clock cycles after each frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2048, maximum cycles to wait for tx_done.
REQ-003 aclk  in  1  GMII TX clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 arp_req  in  1  one-cycle pulse: ARP request validated by receiver.
REQ-006 arp_req_mac  in  48  requester MAC, sampled when arp_req=1.
REQ-007 udp_req  in  1  level: UDP/IPv4 frame ready, held until udp_grant.
REQ-008 udp_dst_mac  in  48  destination MAC for UDP frame, stable while udp_req=1.
REQ-009 tx_done  in  1  one-cycle pulse from frame builder: frame (incl. FCS) sent.
REQ-010 tx_start  out  1  one-cycle pulse: frame builder begins frame.
REQ-011 tx_type  out  1  0=ARP reply, 1=IPv4; valid with tx_start, held until next grant.
REQ-012 tx_dst_mac  out  48  destination MAC; valid with tx_start, held until next grant.
REQ-013 udp_grant  out  1  one-cycle pulse, coincident with tx_start when tx_type=1.
REQ-014 arp_drop  out  1  one-cycle pulse: arp_req lost because one ARP already pending.
REQ-015 tx_timeout  out  1  one-cycle pulse: tx_done not received within TIMEOUT_CYCLES.
REQ-016 busy  out  1  1 whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, WAIT_DONE, IFG.
REQ-018 arp_req SHALL set arp_pending and latch arp_req_mac on the next edge; pending is one-deep.
REQ-019 arp_req while arp_pending=1 and not consumed that cycle SHALL keep the stored MAC and pulse arp_drop next cycle.
REQ-020 arp_req in the same cycle a grant consumes arp_pending SHALL become the new pending entry; no arp_drop.
REQ-021 IDLE with any request pending SHALL transition to WAIT_DONE, asserting tx_start (registered) in the following cycle.
REQ-022 Only ARP pending -> grant ARP; only udp_req -> grant UDP; both -> grant type opposite to last_grant (round-robin).
REQ-023 last_grant SHALL reset to UDP, so the first contended grant goes to ARP.
REQ-024 Latency: arp_req at cycle N in IDLE, no contention -> tx_start=1 at cycle N+2.
REQ-025 WAIT_DONE SHALL count cycles from 0; tx_done -> IFG; count reaching TIMEOUT_CYCLES-1 without tx_done -> pulse tx_timeout, go IFG.
REQ-026 tx_done outside WAIT_DONE SHALL be ignored.
REQ-027 IFG SHALL last exactly IFG_CYCLES cycles then return to IDLE; requests arriving in WAIT_DONE/IFG SHALL be held pending.
REQ-028 Counters SHALL be sized clog2 of their parameter; no wrap beyond terminal count.

Reset
REQ-029 aresetn=0 at a clock edge SHALL force IDLE, clear arp_pending, counters, tx_start, udp_grant, arp_drop, tx_timeout, busy, tx_type=0, tx_dst_mac=0, last_grant=UDP.
REQ-030 Reset mid-frame SHALL abandon the grant without pulsing tx_timeout; requests seen during reset SHALL be discarded.

Structure
REQ-031 State enum, TX_TYPE_ARP/TX_TYPE_IP constants and default IFG/timeout values SHALL live in shared package eth_pkg.
REQ-032 SHALL be one module with one optional sub-module rr_arb2 (2-way round-robin with last_grant register).

Verification
REQ-033 arp_req at cycle 10 with MAC 02:00:00:00:00:01 -> tx_start, tx_type=0, tx_dst_mac=020000000001 at cycle 12.
REQ-034 arp_req and udp_req together from reset -> ARP first; after tx_done + 12 IFG cycles -> UDP with udp_grant=1.
REQ-035 Second arp_req during WAIT_DONE with ARP already pending -> arp_drop pulse one cycle later, stored MAC unchanged.
REQ-036 No tx_done after grant -> tx_timeout pulse after 2048 cycles in WAIT_DONE, then IFG, then pending served.
REQ-037 aresetn=0 during WAIT_DONE -> next cycle busy=0, all pulses 0, no timeout, no stale grant after release.
REQ-038 tx_done injected in IDLE -> no state change, no outputs.
